// File: rtl/fixed_round_stream.sv
// Two-stage signed fixed-point requantiser: shift/guard/sticky capture, then
// mode-dependent rounding with saturation, behind a valid/ready stream.
module fixed_round_stream #(
  parameter int IN_WIDTH       = 16,
  parameter int IN_FRAC_WIDTH  = 8,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 4,
  parameter int PARALLELISM    = 4,
  parameter int SAT_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      data_in [PARALLELISM],
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  input  logic [1:0]               round_mode,
  output logic [OUT_WIDTH-1:0]     data_out [PARALLELISM],
  output logic [PARALLELISM-1:0]   data_out_sat,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  input  logic                     sat_clear,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  typedef enum logic [1:0] {
    RM_FLOOR     = 2'd0,
    RM_HALF_UP   = 2'd1,
    RM_HALF_EVEN = 2'd2,
    RM_HALF_AWAY = 2'd3
  } round_mode_e;

  localparam int SHIFT = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
  localparam int IW    = IN_WIDTH + LSH + 1;
  // Compare width covers both the shifted value and the output range.
  localparam int CW    = ((IW > OUT_WIDTH) ? IW : OUT_WIDTH) + 1;
  localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_V = {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                   rdy_en;
  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s2_adv;
  logic                   s1_load;
  round_mode_e            s1_mode;
  logic signed [IW-1:0]   q_d  [PARALLELISM];
  logic signed [IW-1:0]   s1_q [PARALLELISM];
  logic [PARALLELISM-1:0] g_d;
  logic [PARALLELISM-1:0] st_d;
  logic [PARALLELISM-1:0] s1_g;
  logic [PARALLELISM-1:0] s1_s;
  logic [PARALLELISM-1:0] sat_d;
  logic [OUT_WIDTH-1:0]   res_d [PARALLELISM];

  assign s2_adv         = !s2_valid || data_out_ready;
  assign data_in_ready  = rdy_en && (!s1_valid || s2_adv);
  assign s1_load        = data_in_valid && data_in_ready;
  assign data_out_valid = s2_valid;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    logic signed [IW-1:0]  ext;
    logic                  inc;
    logic signed [CW-1:0]  sum;
    logic                  sat_l;
    logic [OUT_WIDTH-1:0]  res_l;

    assign ext = {{(IW-IN_WIDTH){data_in[i][IN_WIDTH-1]}}, data_in[i]};

    if (SHIFT > 0) begin : g_rshift
      assign q_d[i] = ext >>> SHIFT;
      assign g_d[i] = data_in[i][SHIFT-1];
      if (SHIFT > 1) begin : g_sticky
        assign st_d[i] = |data_in[i][SHIFT-2:0];
      end else begin : g_nosticky
        assign st_d[i] = 1'b0;
      end
    end else begin : g_lshift
      assign q_d[i]  = ext <<< LSH;
      assign g_d[i]  = 1'b0;
      assign st_d[i] = 1'b0;
    end

    always_comb begin
      inc = 1'b0;
      case (s1_mode)
        RM_FLOOR:     inc = 1'b0;
        RM_HALF_UP:   inc = s1_g[i];
        RM_HALF_EVEN: inc = s1_g[i] && (s1_s[i] || s1_q[i][0]);
        RM_HALF_AWAY: inc = s1_g[i] && (s1_s[i] || !s1_q[i][IW-1]);
        default:      inc = 1'b0;
      endcase
    end

    assign sum = {{(CW-IW){s1_q[i][IW-1]}}, s1_q[i]} + {{(CW-1){1'b0}}, inc};

    always_comb begin
      sat_l = 1'b0;
      res_l = sum[OUT_WIDTH-1:0];
      if (sum > MAX_V) begin
        sat_l = 1'b1;
        res_l = MAX_V[OUT_WIDTH-1:0];
      end else if (sum < MIN_V) begin
        sat_l = 1'b1;
        res_l = MIN_V[OUT_WIDTH-1:0];
      end
    end

    assign sat_d[i] = sat_l;
    assign res_d[i] = res_l;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      s1_mode  <= RM_FLOOR;
      s1_g     <= '0;
      s1_s     <= '0;
      for (int unsigned i = 0; i < PARALLELISM; i++) s1_q[i] <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (data_in_ready) s1_valid <= data_in_valid;
      if (s1_load) begin
        s1_mode <= round_mode_e'(round_mode);
        s1_g    <= g_d;
        s1_s    <= st_d;
        for (int unsigned i = 0; i < PARALLELISM; i++) s1_q[i] <= q_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid     <= 1'b0;
      data_out_sat <= '0;
      for (int unsigned i = 0; i < PARALLELISM; i++) data_out[i] <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_out_sat <= sat_d;
        for (int unsigned i = 0; i < PARALLELISM; i++) data_out[i] <= res_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (s2_valid && data_out_ready && (|data_out_sat) && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fixed_round_stream.sv
// Directed bench for fixed_round_stream at IN 8/3, OUT 4/1, four lanes,
// 4-bit saturation counter.
module tb_fixed_round_stream;

  localparam int MAXB = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in [4];
  logic       data_in_valid;
  logic       data_in_ready;
  logic [1:0] round_mode;
  logic [3:0] data_out [4];
  logic [3:0] data_out_sat;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       sat_clear;
  logic [3:0] sat_count;

  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;

  typedef struct {
    logic [3:0][7:0] din;
    logic [1:0]      mode;
    logic [3:0][3:0] dout;
    logic [3:0]      sat;
  } vec_t;

  vec_t vecs [8];

  logic [3:0][7:0] st_in   [MAXB];
  logic [1:0]      st_mode [MAXB];
  logic [3:0][3:0] st_exp  [MAXB];
  logic [3:0]      st_sat  [MAXB];
  logic            st_pat  [4];

  fixed_round_stream #(
    .IN_WIDTH(8),
    .IN_FRAC_WIDTH(3),
    .OUT_WIDTH(4),
    .OUT_FRAC_WIDTH(1),
    .PARALLELISM(4),
    .SAT_CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .round_mode(round_mode),
    .data_out(data_out),
    .data_out_sat(data_out_sat),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .sat_clear(sat_clear),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0][7:0] lanes8(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [3:0][3:0] lanes4(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [3:0][3:0] pack_out();
    logic [3:0][3:0] r;
    for (int j = 0; j < 4; j++) r[j] = data_out[j];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_beat(input logic [3:0][7:0] d, input logic [1:0] m);
    for (int j = 0; j < 4; j++) data_in[j] = d[j];
    round_mode    = m;
    data_in_valid = 1'b1;
  endtask

  task automatic set_pat(input logic a, input logic b, input logic c, input logic d);
    st_pat[0] = a; st_pat[1] = b; st_pat[2] = c; st_pat[3] = d;
  endtask

  // Streams st_in[0..n-1] while toggling data_out_ready by st_pat, checking
  // order, stall stability and the ready/occupancy relation each cycle.
  task automatic run_stream(input int n);
    int sent = 0;
    int rcv  = 0;
    int occ  = 0;
    int cyc  = 0;
    logic held_v = 1'b0;
    logic [3:0][3:0] held_d = '0;
    logic [3:0] held_s = '0;
    logic acc, xfer, exp_rdy;
    logic [3:0][3:0] act;
    while (rcv < n && cyc < 200) begin
      @(posedge clk); #1;
      if (sent < n) drive_beat(st_in[sent], st_mode[sent]);
      else data_in_valid = 1'b0;
      data_out_ready = st_pat[cyc % 4];
      @(negedge clk);
      exp_rdy = !(occ == 2 && !data_out_ready);
      check("in_ready", 32'(data_in_ready), 32'(exp_rdy));
      acc  = data_in_valid && data_in_ready;
      xfer = data_out_valid && data_out_ready;
      act  = pack_out();
      if (held_v) begin
        check("stall_valid", 32'(data_out_valid), 32'd1);
        check("stall_data", 32'(act), 32'(held_d));
        check("stall_sat", 32'(data_out_sat), 32'(held_s));
      end
      if (xfer) begin
        if (rcv < n) begin
          check("out_data", 32'(act), 32'(st_exp[rcv]));
          check("out_sat", 32'(data_out_sat), 32'(st_sat[rcv]));
          if (|st_sat[rcv]) model_cnt = (model_cnt == 15) ? 15 : model_cnt + 1;
        end
        rcv++;
      end
      held_v = data_out_valid && !data_out_ready;
      held_d = act;
      held_s = data_out_sat;
      occ  = occ + int'(acc) - int'(xfer);
      sent = sent + int'(acc);
      cyc++;
    end
    check("stream_done", 32'(rcv), 32'(n));
    data_in_valid = 1'b0;
  endtask

  task automatic check_count();
    @(posedge clk); #1;
    check("sat_count", 32'(sat_count), 32'(model_cnt));
  endtask

  initial begin
    bit saw_valid;
    int m;

    vecs[0] = '{lanes8(8'h12, 8'hEE, 8'h00, 8'h16), 2'd0, lanes4(4'h4, 4'hB, 4'h0, 4'h5), 4'b0000};
    vecs[1] = '{lanes8(8'h12, 8'hEE, 8'h00, 8'h16), 2'd1, lanes4(4'h5, 4'hC, 4'h0, 4'h6), 4'b0000};
    vecs[2] = '{lanes8(8'h12, 8'hEE, 8'h00, 8'h16), 2'd2, lanes4(4'h4, 4'hC, 4'h0, 4'h6), 4'b0000};
    vecs[3] = '{lanes8(8'h12, 8'hEE, 8'h00, 8'h16), 2'd3, lanes4(4'h5, 4'hB, 4'h0, 4'h6), 4'b0000};
    vecs[4] = '{lanes8(8'h50, 8'h80, 8'h1F, 8'h00), 2'd0, lanes4(4'h7, 4'h8, 4'h7, 4'h0), 4'b0011};
    vecs[5] = '{lanes8(8'h50, 8'h80, 8'h1F, 8'h00), 2'd1, lanes4(4'h7, 4'h8, 4'h7, 4'h0), 4'b0111};
    vecs[6] = '{lanes8(8'h3F, 8'hC0, 8'h0E, 8'hF1), 2'd3, lanes4(4'h7, 4'h8, 4'h4, 4'hC), 4'b0011};
    vecs[7] = '{lanes8(8'h1C, 8'hE0, 8'h1D, 8'hE3), 2'd2, lanes4(4'h7, 4'h8, 4'h7, 4'h9), 4'b0000};

    rst = 1'b0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    round_mode = 2'd0;
    sat_clear = 1'b0;
    for (int j = 0; j < 4; j++) data_in[j] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_count", 32'(sat_count), 32'd0);
    check("rst_data", 32'(pack_out()), 32'd0);
    check("rst_sat", 32'(data_out_sat), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(data_in_ready), 32'd1);

    set_pat(1'b1, 1'b1, 1'b1, 1'b1);
    for (int v = 0; v < 8; v++) begin
      st_in[0] = vecs[v].din;
      st_mode[0] = vecs[v].mode;
      st_exp[0] = vecs[v].dout;
      st_sat[0] = vecs[v].sat;
      run_stream(1);
      check_count();
    end

    // Backpressure: 8 beats with ready pattern 1,0,0,1
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        m = k + j - 8;
        st_in[k][j]  = 8'(4 * m);
        st_exp[k][j] = 4'(m);
      end
      st_mode[k] = 2'd0;
      st_sat[k]  = 4'b0000;
    end
    set_pat(1'b1, 1'b0, 1'b0, 1'b1);
    run_stream(8);
    check_count();

    // Mode switch between consecutive beats
    set_pat(1'b1, 1'b1, 1'b1, 1'b1);
    st_in[0] = lanes8(8'h12, 8'h12, 8'h12, 8'h12); st_mode[0] = 2'd0;
    st_exp[0] = lanes4(4'h4, 4'h4, 4'h4, 4'h4);    st_sat[0] = 4'b0000;
    st_in[1] = lanes8(8'h12, 8'h12, 8'h12, 8'h12); st_mode[1] = 2'd2;
    st_exp[1] = lanes4(4'h4, 4'h4, 4'h4, 4'h4);    st_sat[1] = 4'b0000;
    run_stream(2);
    st_in[0] = lanes8(8'h16, 8'h16, 8'h16, 8'h16); st_mode[0] = 2'd0;
    st_exp[0] = lanes4(4'h5, 4'h5, 4'h5, 4'h5);    st_sat[0] = 4'b0000;
    st_in[1] = lanes8(8'h16, 8'h16, 8'h16, 8'h16); st_mode[1] = 2'd2;
    st_exp[1] = lanes4(4'h6, 4'h6, 4'h6, 4'h6);    st_sat[1] = 4'b0000;
    run_stream(2);

    // Reset with two saturating beats in flight
    @(posedge clk); #1;
    data_out_ready = 1'b0;
    drive_beat(lanes8(8'h50, 8'h50, 8'h50, 8'h50), 2'd0);
    @(posedge clk); #1;
    drive_beat(lanes8(8'h80, 8'h80, 8'h80, 8'h80), 2'd0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    check("inflight_valid", 32'(data_out_valid), 32'd1);
    check("pre_rst_count", 32'(sat_count), 32'(model_cnt));
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(data_out_valid), 32'd0);
    check("midrst_count", 32'(sat_count), 32'd0);
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    data_out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (data_out_valid) saw_valid = 1'b1;
    end
    check("no_stale_beat", 32'(saw_valid), 32'd0);
    check("post_rst_count", 32'(sat_count), 32'd0);

    // sat_clear against a simultaneous saturating transfer
    st_in[0] = lanes8(8'h50, 8'h00, 8'h00, 8'h00); st_mode[0] = 2'd0;
    st_exp[0] = lanes4(4'h7, 4'h0, 4'h0, 4'h0);    st_sat[0] = 4'b0001;
    run_stream(1);
    check_count();
    data_out_ready = 1'b0;
    drive_beat(lanes8(8'h50, 8'h50, 8'h00, 8'h00), 2'd0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr_pending_valid", 32'(data_out_valid), 32'd1);
    check("clr_pending_sat", 32'(data_out_sat), 32'h3);
    data_out_ready = 1'b1;
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    model_cnt = 0;
    check("clr_count", 32'(sat_count), 32'd0);
    check("clr_drained", 32'(data_out_valid), 32'd0);

    // Counter saturation at all-ones
    for (int k = 0; k < 15; k++) begin
      st_in[k]  = lanes8(8'h80, 8'h80, 8'h80, 8'h80);
      st_mode[k] = 2'd0;
      st_exp[k] = lanes4(4'h8, 4'h8, 4'h8, 4'h8);
      st_sat[k] = 4'b1111;
    end
    run_stream(15);
    check_count();
    run_stream(1);
    check_count();
    check("count_max", 32'(sat_count), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
